// File: rtl/params_noc.sv
// rtl/params_noc.sv - shared NoC types for the input route controller
//
// Purpose: flit format, output port encoding and controller state type.
// Ports:   none (package).

package params_noc;

  localparam int X_W       = 4;
  localparam int Y_W       = 4;
  localparam int PAYLOAD_W = 24;

  typedef logic [X_W-1:0] x_Des;
  typedef logic [Y_W-1:0] y_Des;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    x_Des                 x_Dest;
    y_Des                 y_Dest;
    logic [PAYLOAD_W-1:0] data;
  } flit_Data_noVC;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } route_state_t;

endpackage

// File: rtl/xy_route_calc.sv
// rtl/xy_route_calc.sv - combinational dimension-ordered (X then Y) route selection
//
// Purpose: pick the output port for a destination relative to this router.
// Ports:   x_dest, y_dest - destination coordinates of the flit
//          port           - selected output port

module xy_route_calc
  import params_noc::*;
#(
  parameter x_Des X_CUR = '0,
  parameter y_Des Y_CUR = '0
) (
  input  x_Des  x_dest,
  input  y_Des  y_dest,
  output port_t port
);

  // X is resolved completely before Y is considered, which keeps the
  // routing deadlock-free on a mesh.
  always_comb begin
    port = LOCAL;
    if (x_dest > X_CUR) begin
      port = EAST;
    end else if (x_dest < X_CUR) begin
      port = WEST;
    end else if (y_dest > Y_CUR) begin
      port = NORTH;
    end else if (y_dest < Y_CUR) begin
      port = SOUTH;
    end
  end

endmodule

// File: rtl/input_route_ctrl.sv
// rtl/input_route_ctrl.sv - per-input packet routing stage between buffer and switch
//
// Purpose: pops flits from the input buffer, routes HEAD/HEADTAIL flits with
//          XY routing, forwards BODY/TAIL on the latched route through a
//          one-entry output register, flags protocol errors and counts packets.
// Ports:   clk, rst_n                     - clock, synchronous active-low reset
//          buf_empty, buf_data            - FWFT buffer head and empty flag
//          buf_read_o                     - buffer pop strobe
//          out_flit_o, out_port_o,
//          out_valid_o, out_ready_i       - output stage handshake
//          err_o                          - one-cycle protocol error pulse
//          pkt_cnt_o                      - completed packet count

module input_route_ctrl
  import params_noc::*;
#(
  parameter x_Des X_CUR = '0,
  parameter y_Des Y_CUR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buf_empty,
  input  flit_Data_noVC buf_data,
  output logic          buf_read_o,
  output flit_Data_noVC out_flit_o,
  output port_t         out_port_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          err_o,
  output logic [15:0]   pkt_cnt_o
);

  route_state_t state_q, state_d;
  port_t        calc_port;
  port_t        route_q;
  port_t        load_port;
  logic         pop;
  logic         load;
  logic         err_d;
  logic         cnt_inc;

  // Pop only when the output register is free or is being drained this edge,
  // so a pop and an accept on the same edge give a bubble-free hand-off.
  assign pop        = rst_n && !buf_empty && (!out_valid_o || out_ready_i);
  assign buf_read_o = pop;

  xy_route_calc #(
    .X_CUR(X_CUR),
    .Y_CUR(Y_CUR)
  ) u_route (
    .x_dest(buf_data.x_Dest),
    .y_dest(buf_data.y_Dest),
    .port  (calc_port)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_port = route_q;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;
    if (pop) begin
      case (buf_data.flit_label)
        HEAD, HEADTAIL: begin
          // A head always starts a fresh packet; arriving mid-packet it
          // abandons the old one and is flagged.
          load      = 1'b1;
          load_port = calc_port;
          err_d     = (state_q == ACTIVE);
          state_d   = (buf_data.flit_label == HEAD) ? ACTIVE : IDLE;
          cnt_inc   = (buf_data.flit_label == HEADTAIL);
        end
        BODY, TAIL: begin
          if (state_q == ACTIVE) begin
            load    = 1'b1;
            state_d = (buf_data.flit_label == TAIL) ? IDLE : ACTIVE;
            cnt_inc = (buf_data.flit_label == TAIL);
          end else begin
            // Orphan flit with no route: consumed from the buffer and dropped.
            err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_flit_o  <= '0;
      out_port_o  <= LOCAL;
      out_valid_o <= 1'b0;
      route_q     <= LOCAL;
      err_o       <= 1'b0;
      pkt_cnt_o   <= '0;
    end else begin
      if (load) begin
        out_flit_o  <= buf_data;
        out_port_o  <= load_port;
        out_valid_o <= 1'b1;
        route_q     <= load_port;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      err_o <= err_d;
      if (cnt_inc) begin
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_input_route_ctrl.sv
// tb/tb_input_route_ctrl.sv - directed self-checking bench for input_route_ctrl

module tb_input_route_ctrl;
  import params_noc::*;

  typedef struct {
    flit_Data_noVC f;
    port_t         p;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          buf_empty;
  flit_Data_noVC buf_data;
  logic          buf_read_o;
  flit_Data_noVC out_flit_o;
  port_t         out_port_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          err_o;
  logic [15:0]   pkt_cnt_o;

  flit_Data_noVC fifo[$];
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          last_pop;
  flit_Data_noVC hold_flit;

  input_route_ctrl #(
    .X_CUR(4'd2),
    .Y_CUR(4'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buf_empty  (buf_empty),
    .buf_data   (buf_data),
    .buf_read_o (buf_read_o),
    .out_flit_o (out_flit_o),
    .out_port_o (out_port_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .err_o      (err_o),
    .pkt_cnt_o  (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic flit_Data_noVC mk(flit_label_t l, int x, int y, int d);
    flit_Data_noVC f;
    f.flit_label = l;
    f.x_Dest     = x_Des'(x);
    f.y_Dest     = y_Des'(y);
    f.data       = 24'(d);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_buf();
    buf_empty = (fifo.size() == 0);
    buf_data  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push(input flit_Data_noVC f, input logic expect_out, input port_t p);
    exp_t e;
    fifo.push_back(f);
    if (expect_out) begin
      e.f = f;
      e.p = p;
      exp_q.push_back(e);
    end
    drive_buf();
  endtask

  // One clock: sample handshakes at the falling edge, pop the buffer model
  // and score any accepted flit 1 time unit after the rising edge.
  task automatic step();
    logic          p;
    logic          acc;
    flit_Data_noVC of;
    port_t         op;
    @(negedge clk);
    p   = buf_read_o;
    acc = out_valid_o && out_ready_i && rst_n;
    of  = out_flit_o;
    op  = out_port_o;
    @(posedge clk);
    #1;
    last_pop = p;
    if (p && fifo.size() != 0) void'(fifo.pop_front());
    drive_buf();
    if (acc) begin
      chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("sb_flit", 64'(of), 64'(exp_q[0].f));
        chk("sb_port", 64'(op), 64'(exp_q[0].p));
        void'(exp_q.pop_front());
      end
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    out_ready_i = 1'b1;
    last_pop    = 1'b0;
    drive_buf();

    // Reset: buffer non-empty but no pop allowed
    push(mk(HEADTAIL, 2, 2, 'h11), 1'b1, LOCAL);
    step();
    chk("rst_no_pop", 64'(last_pop), 64'd0);
    step();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_port", 64'(out_port_o), 64'(LOCAL));
    chk("rst_flit", 64'(out_flit_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);

    // Single-flit packets: LOCAL, SOUTH, WEST
    rst_n = 1'b1;
    step();
    chk("ht_local_pop", 64'(last_pop), 64'd1);
    chk("ht_local_valid", 64'(out_valid_o), 64'd1);
    chk("ht_local_port", 64'(out_port_o), 64'(LOCAL));
    chk("ht_local_cnt", 64'(pkt_cnt_o), 64'd1);
    chk("ht_local_state", 64'(dut.state_q), 64'(IDLE));
    push(mk(HEADTAIL, 2, 0, 'h12), 1'b1, SOUTH);
    push(mk(HEADTAIL, 0, 3, 'h13), 1'b1, WEST);
    step();
    chk("ht_south_port", 64'(out_port_o), 64'(SOUTH));
    chk("ht_south_cnt", 64'(pkt_cnt_o), 64'd2);
    step();
    chk("ht_west_port", 64'(out_port_o), 64'(WEST));
    chk("ht_west_cnt", 64'(pkt_cnt_o), 64'd3);
    step();
    chk("ht_drain_valid", 64'(out_valid_o), 64'd0);

    // 4-flit packet to EAST; body flits carry coordinates that would route WEST
    push(mk(HEAD, 3, 0, 'h21), 1'b1, EAST);
    push(mk(BODY, 0, 0, 'h22), 1'b1, EAST);
    push(mk(BODY, 0, 0, 'h23), 1'b1, EAST);
    push(mk(TAIL, 0, 0, 'h24), 1'b1, EAST);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("east_valid", 64'(out_valid_o), 64'd1);
      chk("east_port", 64'(out_port_o), 64'(EAST));
      chk("east_err", 64'(err_o), 64'd0);
    end
    chk("east_cnt", 64'(pkt_cnt_o), 64'd4);
    step();
    chk("east_drain_valid", 64'(out_valid_o), 64'd0);

    // Back-pressure: NORTH packet stalled 5 cycles after its first flit
    hold_flit = mk(HEAD, 2, 3, 'h31);
    push(hold_flit, 1'b1, NORTH);
    push(mk(BODY, 1, 1, 'h32), 1'b1, NORTH);
    push(mk(BODY, 1, 1, 'h33), 1'b1, NORTH);
    push(mk(TAIL, 1, 1, 'h34), 1'b1, NORTH);
    step();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_pop", 64'(last_pop), 64'd0);
      chk("stall_valid", 64'(out_valid_o), 64'd1);
      chk("stall_flit", 64'(out_flit_o), 64'(hold_flit));
      chk("stall_port", 64'(out_port_o), 64'(NORTH));
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_cnt", 64'(pkt_cnt_o), 64'd5);
    chk("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // Orphan BODY in IDLE is popped and dropped with an error pulse
    push(mk(BODY, 3, 0, 'h41), 1'b0, LOCAL);
    step();
    chk("orphan_pop", 64'(last_pop), 64'd1);
    chk("orphan_valid", 64'(out_valid_o), 64'd0);
    chk("orphan_err", 64'(err_o), 64'd1);
    step();
    chk("orphan_err_clr", 64'(err_o), 64'd0);
    chk("orphan_cnt", 64'(pkt_cnt_o), 64'd5);

    // HEAD while ACTIVE: error, new packet routed WEST
    push(mk(HEAD, 3, 0, 'h51), 1'b1, EAST);
    push(mk(HEAD, 1, 2, 'h52), 1'b1, WEST);
    step();
    chk("hh_first_err", 64'(err_o), 64'd0);
    chk("hh_first_port", 64'(out_port_o), 64'(EAST));
    step();
    chk("hh_second_err", 64'(err_o), 64'd1);
    chk("hh_second_port", 64'(out_port_o), 64'(WEST));
    push(mk(TAIL, 0, 0, 'h53), 1'b1, WEST);
    step();
    chk("hh_tail_err", 64'(err_o), 64'd0);
    chk("hh_tail_port", 64'(out_port_o), 64'(WEST));
    chk("hh_cnt", 64'(pkt_cnt_o), 64'd6);
    step();
    chk("hh_drain_valid", 64'(out_valid_o), 64'd0);

    // Reset mid-packet discards the in-flight flit and packet state
    push(mk(HEAD, 3, 0, 'h61), 1'b0, EAST);
    push(mk(BODY, 0, 0, 'h62), 1'b0, LOCAL);
    step();
    chk("mid_head_valid", 64'(out_valid_o), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_no_pop", 64'(last_pop), 64'd0);
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_port", 64'(out_port_o), 64'(LOCAL));
    chk("mid_rst_flit", 64'(out_flit_o), 64'd0);
    chk("mid_rst_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    rst_n = 1'b1;
    step();
    chk("mid_body_pop", 64'(last_pop), 64'd1);
    chk("mid_body_valid", 64'(out_valid_o), 64'd0);
    chk("mid_body_err", 64'(err_o), 64'd1);
    step();
    chk("mid_err_clr", 64'(err_o), 64'd0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("final_fifo_empty", 64'(fifo.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
